sb_datapath: RTL
================

# sb_datapath

Scoreboard datapath for the bowling score board: the responder that sits opposite the scoreboard controller. It accepts pin counts from the lane interface over a valid/ready handshake and validates each roll against the standing pins. It generates the `UPD`/`APD`/`LF` status the controller consumes and executes the controller's `AD` (add) and `NF` (next frame) commands on the running score and the frame counter. It stops accepting rolls once the controller raises `done`.

## Interface
- `HOLD_CYCLES`, default 8: cycles `roll_ready` stays low after each accepted roll. Legal range is 1–15.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `roll_valid`  in  1  roll offered by the lane interface.
- `pins`  in  4  pins knocked down by the offered roll.
- `roll_ready`  out  1  datapath can accept a roll.
- `AD`  in  1  controller add command; level, one add per high cycle.
- `NF`  in  1  controller next-frame command; the rising edge is the event.
- `done`  in  1  controller game-over; level.
- `UPD`  out  1  one-cycle pulse announcing a newly accepted roll.
- `APD`  out  1  all pins down: standing pins == 0.
- `LF`  out  1  last frame: frame == 10.
- `score`  out  9  running total, 0–511.
- `frame`  out  4  current frame, 1–10.
- `err`  out  1  one-cycle pulse when an offered roll is rejected.

## Operation
- Registers:
  - `pins_left` (4b, reset 10)
  - `pin_reg` (4b, reset 0)
  - `score` (9b, reset 0)
  - `frame` (4b, reset 1)
  - `hold_cnt` (4b, reset 0)
  - `nf_d` (1b, reset 0)
  - `UPD` and `err` (reset 0)
- Reset values of the outputs: `UPD`=0, `err`=0, `APD`=0, `LF`=0, `score`=0, `frame`=1, `roll_ready`=1.
- `roll_ready` = (`hold_cnt`==0) && !`done`. This is combinational from registers.
- Handshake: a roll is offered when `roll_valid` && `roll_ready` is sampled high on an edge. The offer is then checked against the effective standing pins:
  - Effective standing pins = 10 if `pins_left`==0 or an `NF` rising edge is sampled on the same edge (rack reset, which covers bonus rolls); otherwise `pins_left`.
  - Accept when `pins` <= effective standing pins:
    - `pin_reg` <= `pins`
    - `pins_left` <= effective − `pins`
    - `UPD` <= 1
    - `hold_cnt` <= `HOLD_CYCLES`
  - Reject when `pins` > effective standing pins, including `pins` > 10:
    - `err` <= 1.
    - `pin_reg`, `pins_left`, `UPD`, `hold_cnt` and `score` are unchanged.
    - `roll_ready` stays high.
- `UPD` and `err` clear on the following edge; each is exactly one cycle wide.
- `hold_cnt` decrements by 1 per cycle while nonzero.
- `APD` = (`pins_left`==0). `LF` = (`frame`==10). Both are combinational from registers.
- Add: on every edge with `AD`=1, `score` <= `score` + `pin_reg`, saturating at 511. An `AD` held for N cycles adds N×`pin_reg`; this is how the controller applies strike and spare bonuses.
- Next frame:
  - `nf_d` <= `NF` each cycle. A rising edge is `NF` && !`nf_d`.
  - On a rising edge: `frame` <= min(`frame`+1, 10) and `pins_left` <= 10, unless the same edge accepts a roll, in which case the accept result above wins.
  - `NF` held high produces only one increment.
- `done`=1:
  - `roll_ready`=0 and no accepts or rejects occur (`roll_valid` is ignored).
  - `AD` adds and `NF` frame advances are ignored, so `score` and `frame` are frozen.
- Simultaneous `AD` and accept on the same edge: the add uses the old `pin_reg`.

## Timing
- Accept latency: roll sampled at edge T → `UPD`=1, new `pin_reg`, new `pins_left` and new `APD` all visible in cycle T..T+1. `UPD` falls at T+1.
- `roll_ready` is low for exactly `HOLD_CYCLES` cycles after edge T and high again after edge T+`HOLD_CYCLES` (when `done`=0).
- Reject: `err` is high for the one cycle after the sampling edge; there is no other visible change.
- Add: `score` updates one edge after each `AD`-high sample.
- `NF` rising edge sampled at T → `frame`, `LF` and `pins_left` update after T.
- Asynchronous reset mid-operation: all registers return to their reset values immediately. `UPD` or `err` in flight are dropped, and `roll_ready` is 1 on reset release.

## Test plan
- Reset check: assert `reset` mid-game with `score`=57, `frame`=4, `hold_cnt`≠0. Required: `score`=0, `frame`=1, `APD`=0, `LF`=0, `UPD`=0, `err`=0, `roll_ready`=1 while reset is high.
- Open frame:
  - Roll 7 → `UPD` pulse of 1 cycle, `APD`=0, `roll_ready` low for 8 cycles.
  - `AD` held 1 cycle → `score`=7.
  - Roll 2 followed by 1 `AD` cycle → `score`=9, `pins_left`=1.
  - `NF` pulse → `frame`=2, `pins_left`=10.
- Strike with bonus adds:
  - Roll 10 → `APD`=1 in the `UPD` cycle.
  - `AD` high 3 consecutive cycles → `score` rises by 30.
  - Next roll of 4 without `NF` is accepted (rack reset) → `pins_left`=6.
- Rejects:
  - With `pins_left`=3, offer 5 → `err` 1 cycle, no `UPD`, `pins_left`=3.
  - Offer `pins`=11 on a fresh rack → `err`, no `UPD`.
- Frame limit: 12 `NF` pulses, one held high for 4 cycles → `frame` steps to 10 and holds, `LF`=1 from the 9th pulse onward.
- Done and saturation:
  - Preload `score`=505, `pin_reg`=10, `AD` 1 cycle → `score`=511.
  - Raise `done` → `roll_ready`=0; `roll_valid`, `AD` and `NF` cause no change to `score`, `frame` or `err`.

Source files
------------

// File: rtl/sb_datapath.sv
// ============================================================================
// sb_datapath : bowling scoreboard datapath (roll intake, score, frame count)
// Rev 1.0
// ============================================================================
`default_nettype none

module sb_datapath #(
  parameter int HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_valid,
  input  logic [3:0] pins,
  output logic       roll_ready,
  input  logic       AD,
  input  logic       NF,
  input  logic       done,
  output logic       UPD,
  output logic       APD,
  output logic       LF,
  output logic [8:0] score,
  output logic [3:0] frame,
  output logic       err
);

  localparam logic [3:0] c_rack      = 4'd10;
  localparam logic [3:0] c_last_frm  = 4'd10;
  localparam logic [3:0] c_hold      = 4'(HOLD_CYCLES);
  localparam logic [8:0] c_score_max = 9'd511;

  logic [3:0] pins_left_q, pins_left_d;
  logic [3:0] pin_reg_q,   pin_reg_d;
  logic [8:0] score_q,     score_d;
  logic [3:0] frame_q,     frame_d;
  logic [3:0] hold_cnt_q,  hold_cnt_d;
  logic       nf_dly_q,    nf_dly_d;
  logic       upd_q,       upd_d;
  logic       err_q,       err_d;

  logic       w_nf_rise;
  logic [3:0] w_avail;
  logic       w_offer;
  logic       w_fits;
  logic [9:0] w_sum;

  assign roll_ready = (hold_cnt_q == 4'd0) && !done;
  assign APD        = (pins_left_q == 4'd0);
  assign LF         = (frame_q == c_last_frm);
  assign score      = score_q;
  assign frame      = frame_q;
  assign UPD        = upd_q;
  assign err        = err_q;

  always_comb begin
    w_nf_rise = NF && !nf_dly_q;
    // A cleared rack or a same-edge next-frame both present a full rack.
    w_avail   = ((pins_left_q == 4'd0) || w_nf_rise) ? c_rack : pins_left_q;
    w_offer   = roll_valid && roll_ready;
    w_fits    = (pins <= w_avail);
    w_sum     = {1'b0, score_q} + {6'd0, pin_reg_q};

    pins_left_d = pins_left_q;
    pin_reg_d   = pin_reg_q;
    score_d     = score_q;
    frame_d     = frame_q;
    hold_cnt_d  = (hold_cnt_q != 4'd0) ? (hold_cnt_q - 4'd1) : hold_cnt_q;
    nf_dly_d    = NF;
    upd_d       = 1'b0;
    err_d       = 1'b0;

    if (AD && !done) begin
      score_d = w_sum[9] ? c_score_max : w_sum[8:0];
    end

    if (w_nf_rise && !done) begin
      frame_d     = (frame_q == c_last_frm) ? c_last_frm : (frame_q + 4'd1);
      pins_left_d = c_rack;
    end

    // An accepted roll overrides the rack reset from a coincident next-frame.
    if (w_offer && w_fits) begin
      pin_reg_d   = pins;
      pins_left_d = w_avail - pins;
      upd_d       = 1'b1;
      hold_cnt_d  = c_hold;
    end else if (w_offer) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins_left_q <= c_rack;
      pin_reg_q   <= 4'd0;
      score_q     <= 9'd0;
      frame_q     <= 4'd1;
      hold_cnt_q  <= 4'd0;
      nf_dly_q    <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pins_left_q <= pins_left_d;
      pin_reg_q   <= pin_reg_d;
      score_q     <= score_d;
      frame_q     <= frame_d;
      hold_cnt_q  <= hold_cnt_d;
      nf_dly_q    <= nf_dly_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
    end
  end

endmodule

`default_nettype wire
